decoding_stage_controller: RTL and testbench

- Sequences the single-FPGA decoding graph through its union-find stages: measurement load, grow/merge iterations until no odd cluster remains, peel, then result hand-off.
- Sits between the syndrome source (valid/ready) and the decoding graph.
- Drives the graph's `stage`, `global_stage` and `measurements` inputs.
- Consumes the graph's registered `busy` and `odd_clusters` outputs.

---
 rtl/decoding_stage_controller.sv | 189 ++++++++++++++++++
 tb/tb_decoding_stage_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decoding_stage_controller.sv
// Stage sequencer for the union-find decoding graph: accepts a syndrome,
// steps the graph through LOAD -> (GROW -> MERGE)* -> PEEL -> RESULT_VALID
// and hands the result to the consumer.
// Optional: define DECODE_CYCLE_COUNTER_EN to build the decode_cycles_o counter;
// without it decode_cycles_o is tied to zero.
//
// state         | meaning
// --------------+----------------------------------------------------------
// ST_IDLE       | waiting for a syndrome, meas_ready_o high
// ST_LOAD       | graph latches measurements (one cycle)
// ST_GROW       | clusters grow for GROW_CYCLES cycles
// ST_MERGE      | settle, then wait for !busy and decide on odd clusters
// ST_PEEL       | settle, then wait for !busy
// ST_RESULT     | result_valid_o high until result_ready_i
module decoding_stage_controller #(
    parameter int PU_COUNT      = 18,
    parameter int STAGE_WIDTH   = 3,
    parameter int GROW_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_ITER      = 2 * PU_COUNT,
    localparam int ITER_W       = $clog2(MAX_ITER + 1)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,            // asynchronous, active low
    input  logic                   meas_valid_i,
    output logic                   meas_ready_o,
    input  logic [PU_COUNT-1:0]    meas_in_i,
    output logic [PU_COUNT-1:0]    measurements_o,
    output logic [STAGE_WIDTH-1:0] stage_o,
    output logic                   global_stage_o,
    input  logic                   busy_i,
    input  logic                   odd_clusters_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [ITER_W-1:0]      iteration_count_o,
    output logic                   timeout_o,
    output logic [15:0]            decode_cycles_o
);

    typedef enum logic [STAGE_WIDTH-1:0] {
        ST_IDLE   = STAGE_WIDTH'(0),
        ST_GROW   = STAGE_WIDTH'(1),
        ST_MERGE  = STAGE_WIDTH'(2),
        ST_PEEL   = STAGE_WIDTH'(3),
        ST_LOAD   = STAGE_WIDTH'(4),
        ST_RESULT = STAGE_WIDTH'(5)
    } stage_e;

    // Timer reloads are "cycles - 1" so the terminal count is zero.
    localparam logic [3:0]        GROW_RELOAD   = 4'(GROW_CYCLES - 1);
    localparam logic [3:0]        SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [ITER_W-1:0] ITER_MAX      = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ITER_LAST     = ITER_W'(MAX_ITER - 1);

    stage_e                stage_q, stage_d;
    logic   [3:0]          timer_q, timer_d;
    logic   [PU_COUNT-1:0] meas_q, meas_d;
    logic   [ITER_W-1:0]   iter_q, iter_d;
    logic                  timeout_q, timeout_d;
    logic                  gstage_q, gstage_d;
    logic                  rvalid_q, rvalid_d;

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stage_q   <= ST_IDLE;
            timer_q   <= '0;
            meas_q    <= '0;
            iter_q    <= '0;
            timeout_q <= 1'b0;
            gstage_q  <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            timer_q   <= timer_d;
            meas_q    <= meas_d;
            iter_q    <= iter_d;
            timeout_q <= timeout_d;
            gstage_q  <= gstage_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Next-state logic; busy/odd_clusters only matter once the settle timer expires.
    always_comb begin
        stage_d   = stage_q;
        timer_d   = timer_q;
        meas_d    = meas_q;
        iter_d    = iter_q;
        timeout_d = timeout_q;
        case (stage_q)
            ST_IDLE: begin
                if (meas_valid_i) begin
                    meas_d    = meas_in_i;
                    iter_d    = '0;
                    timeout_d = 1'b0;
                    stage_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                stage_d = ST_GROW;
                timer_d = GROW_RELOAD;
            end
            ST_GROW: begin
                if (timer_q == 4'd0) begin
                    stage_d = ST_MERGE;
                    timer_d = SETTLE_RELOAD;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            ST_MERGE: begin
                if (timer_q != 4'd0) begin
                    timer_d = timer_q - 4'd1;
                end else if (!busy_i) begin
                    if (!odd_clusters_i) begin
                        stage_d = ST_PEEL;
                        timer_d = SETTLE_RELOAD;
                    end else if (iter_q < ITER_LAST) begin
                        iter_d  = iter_q + ITER_W'(1);
                        stage_d = ST_GROW;
                        timer_d = GROW_RELOAD;
                    end else begin
                        // Iteration budget exhausted with odd clusters left.
                        iter_d    = (iter_q < ITER_MAX) ? iter_q + ITER_W'(1) : iter_q;
                        timeout_d = 1'b1;
                        stage_d   = ST_PEEL;
                        timer_d   = SETTLE_RELOAD;
                    end
                end
            end
            ST_PEEL: begin
                if (timer_q != 4'd0) begin
                    timer_d = timer_q - 4'd1;
                end else if (!busy_i) begin
                    stage_d = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (result_ready_i) begin
                    stage_d = ST_IDLE;
                end
            end
            default: begin
                stage_d = ST_IDLE;
            end
        endcase
        gstage_d = (stage_d != stage_q) && (stage_d != ST_IDLE);
        rvalid_d = (stage_d == ST_RESULT);
    end

`ifdef DECODE_CYCLE_COUNTER_EN
    logic [15:0] dcyc_q, dcyc_d;

    // Decode-length counter: clears on accept, counts active stages, saturates.
    always_comb begin
        dcyc_d = dcyc_q;
        if (stage_q == ST_IDLE) begin
            if (meas_valid_i) begin
                dcyc_d = '0;
            end
        end else if (stage_q != ST_RESULT && dcyc_q != 16'hFFFF) begin
            dcyc_d = dcyc_q + 16'd1;
        end
    end

    // Decode-length counter register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            dcyc_q <= '0;
        end else begin
            dcyc_q <= dcyc_d;
        end
    end

    assign decode_cycles_o = dcyc_q;
`else
    assign decode_cycles_o = '0;
`endif

    assign meas_ready_o      = reset_i && (stage_q == ST_IDLE);
    assign measurements_o    = meas_q;
    assign stage_o           = stage_q;
    assign global_stage_o    = gstage_q;
    assign result_valid_o    = rvalid_q;
    assign iteration_count_o = iter_q;
    assign timeout_o         = timeout_q;

endmodule

// File: tb/tb_decoding_stage_controller.sv
// Randomised and directed bench for decoding_stage_controller. A per-decode
// stage trace is built from the stage rules and compared cycle by cycle.
module tb_decoding_stage_controller;

    localparam int PU = 18;
    localparam int SW = 3;
    localparam int GC = 1;
    localparam int SC = 2;
    localparam int MI = 3;
    localparam int IW = $clog2(MI + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          meas_valid;
    logic          meas_ready;
    logic [PU-1:0] meas_in;
    logic [PU-1:0] measurements;
    logic [SW-1:0] stage;
    logic          gs;
    logic          busy;
    logic          odd;
    logic          rv;
    logic          result_ready;
    logic [IW-1:0] iter;
    logic          tmo;
    logic [15:0]   dcyc;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected trace for one decode, one entry per cycle after the accept edge.
    int q_stage[$];
    int q_iter[$];
    bit q_busy[$];
    bit q_odd[$];
    bit q_rdy[$];
    int m_timeout;
    int m_final_iter;
    int m_active;

    // Graph behaviour for the next decode.
    int stalls[MI];
    bit odds[MI];
    int pstall;
    int hold;

    int lat, pulses, grows;

    decoding_stage_controller #(
        .PU_COUNT(PU), .STAGE_WIDTH(SW), .GROW_CYCLES(GC),
        .SETTLE_CYCLES(SC), .MAX_ITER(MI)
    ) dut (
        .clk_i(clk), .reset_i(rst_n),
        .meas_valid_i(meas_valid), .meas_ready_o(meas_ready),
        .meas_in_i(meas_in), .measurements_o(measurements),
        .stage_o(stage), .global_stage_o(gs),
        .busy_i(busy), .odd_clusters_i(odd),
        .result_valid_o(rv), .result_ready_i(result_ready),
        .iteration_count_o(iter), .timeout_o(tmo),
        .decode_cycles_o(dcyc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic push(input int s, input int it, input bit b, input bit o, input bit r);
        q_stage.push_back(s);
        q_iter.push_back(it);
        q_busy.push_back(b);
        q_odd.push_back(o);
        q_rdy.push_back(r);
    endtask

    task automatic build();
        int it;
        it = 0;
        q_stage.delete(); q_iter.delete(); q_busy.delete(); q_odd.delete(); q_rdy.delete();
        m_timeout = 0;
        push(4, 0, rb(), rb(), rb());
        for (int k = 0; k < MI; k++) begin
            for (int j = 0; j < GC; j++) push(1, it, rb(), rb(), rb());
            for (int j = 0; j < SC - 1; j++) push(2, it, rb(), rb(), rb());
            for (int j = 0; j < stalls[k]; j++) push(2, it, 1'b1, bit'(j % 2), rb());
            push(2, it, 1'b0, odds[k], rb());
            if (!odds[k]) break;
            it++;
            if (it == MI) begin
                m_timeout = 1;
                break;
            end
        end
        for (int j = 0; j < SC - 1; j++) push(3, it, rb(), rb(), rb());
        for (int j = 0; j < pstall; j++) push(3, it, 1'b1, rb(), rb());
        push(3, it, 1'b0, rb(), rb());
        m_active = q_stage.size();
        for (int j = 0; j < hold; j++) push(5, it, rb(), rb(), 1'b0);
        push(5, it, rb(), rb(), 1'b1);
        m_final_iter = it;
    endtask

    task automatic set_graph(input int st, input bit o0, input bit o1, input bit o2,
                             input int ps, input int h);
        for (int k = 0; k < MI; k++) stalls[k] = 0;
        stalls[0] = st;
        odds[0] = o0; odds[1] = o1; odds[2] = o2;
        pstall = ps;
        hold = h;
    endtask

    // Called right after a negedge with the DUT idle.
    task automatic run_decode(input logic [PU-1:0] m, output int o_lat,
                              output int o_pulses, output int o_grows);
        int s;
        o_lat = -1; o_pulses = 0; o_grows = 0;
        meas_valid = 1'b1; meas_in = m;
        busy = rb(); odd = rb(); result_ready = rb();
        for (int t = 0; t < q_stage.size(); t++) begin
            @(negedge clk);
            s = q_stage[t];
            chk("stage", 32'(stage), 32'(s));
            chk("global_stage", 32'(gs), 32'(t == 0 || s != q_stage[t-1]));
            chk("result_valid", 32'(rv), 32'(s == 5));
            chk("meas_ready", 32'(meas_ready), 32'd0);
            chk("measurements", 32'(measurements), 32'(m));
            chk("iteration_count", 32'(iter), 32'(q_iter[t]));
            chk("timeout", 32'(tmo), 32'(m_timeout != 0 && (s == 3 || s == 5)));
`ifdef DECODE_CYCLE_COUNTER_EN
            chk("decode_cycles", 32'(dcyc), 32'((t < m_active) ? t : m_active));
`else
            chk("decode_cycles", 32'(dcyc), 32'd0);
`endif
            if (gs) o_pulses++;
            if (gs && stage == 3'd1) o_grows++;
            if (rv && o_lat < 0) o_lat = t;
            busy = q_busy[t]; odd = q_odd[t]; result_ready = q_rdy[t];
            meas_valid = 1'b1; meas_in = PU'($urandom);
        end
        @(negedge clk);
        meas_valid = 1'b0;
        chk("idle_stage", 32'(stage), 32'd0);
        chk("idle_meas_ready", 32'(meas_ready), 32'd1);
        chk("idle_result_valid", 32'(rv), 32'd0);
        chk("idle_global_stage", 32'(gs), 32'd0);
        chk("idle_measurements", 32'(measurements), 32'(m));
        chk("idle_iteration_count", 32'(iter), 32'(m_final_iter));
        chk("idle_timeout", 32'(tmo), 32'(m_timeout));
`ifdef DECODE_CYCLE_COUNTER_EN
        chk("idle_decode_cycles", 32'(dcyc), 32'(m_active));
`endif
    endtask

    initial begin
        rst_n = 1'b0; meas_valid = 1'b0; meas_in = '0;
        busy = 1'b0; odd = 1'b0; result_ready = 1'b0;
        #1;
        chk("rst_stage", 32'(stage), 32'd0);
        chk("rst_meas_ready", 32'(meas_ready), 32'd0);
        chk("rst_result_valid", 32'(rv), 32'd0);
        chk("rst_measurements", 32'(measurements), 32'd0);
        chk("rst_iteration_count", 32'(iter), 32'd0);
        chk("rst_timeout", 32'(tmo), 32'd0);
        chk("rst_decode_cycles", 32'(dcyc), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_meas_ready", 32'(meas_ready), 32'd1);
        @(negedge clk);

        // Empty syndrome: best-case latency and five stage strobes.
        set_graph(0, 1'b0, 1'b0, 1'b0, 0, 0);
        build();
        run_decode('0, lat, pulses, grows);
        chk("empty_latency", 32'(lat), 32'd6);
        chk("empty_pulses", 32'(pulses), 32'd5);
`ifdef DECODE_CYCLE_COUNTER_EN
        chk("empty_decode_cycles", 32'(dcyc), 32'd6);
`endif

        // Two grow/merge iterations.
        set_graph(0, 1'b1, 1'b0, 1'b0, 0, 0);
        build();
        run_decode(18'h2A5C3, lat, pulses, grows);
        chk("two_iter_grows", 32'(grows), 32'd2);
        chk("two_iter_count", 32'(iter), 32'd1);

        // Busy stall in MERGE with odd_clusters toggling underneath.
        set_graph(10, 1'b0, 1'b0, 1'b0, 0, 0);
        build();
        run_decode(18'h00F0F, lat, pulses, grows);
        chk("stall_grows", 32'(grows), 32'd1);

        // Iteration budget exhausted.
        set_graph(0, 1'b1, 1'b1, 1'b1, 1, 0);
        build();
        run_decode(18'h3FFFF, lat, pulses, grows);
        chk("timeout_grows", 32'(grows), 32'd3);
        chk("timeout_count", 32'(iter), 32'd3);
        chk("timeout_flag", 32'(tmo), 32'd1);

        // Consumer holds off for five cycles while meas_valid stays high.
        set_graph(0, 1'b0, 1'b0, 1'b0, 0, 5);
        build();
        run_decode(18'h12345, lat, pulses, grows);

        // Asynchronous reset in the middle of GROW.
        meas_valid = 1'b1; meas_in = 18'h1ABCD;
        @(negedge clk);
        meas_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_stage", 32'(stage), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_stage", 32'(stage), 32'd0);
        chk("abort_result_valid", 32'(rv), 32'd0);
        chk("abort_measurements", 32'(measurements), 32'd0);
        chk("abort_meas_ready", 32'(meas_ready), 32'd0);
        chk("abort_global_stage", 32'(gs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_release_ready", 32'(meas_ready), 32'd1);
        @(negedge clk);
        chk("abort_no_resume", 32'(stage), 32'd0);

        // Randomised decodes.
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < MI; k++) begin
                stalls[k] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 1)) : 0;
                odds[k] = rb();
            end
            pstall = int'($urandom_range(3, 0));
            hold = int'($urandom_range(4, 0));
            build();
            run_decode(PU'($urandom), lat, pulses, grows);
            if ($urandom_range(1, 0) == 1) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
